sequenciador_exibicao: RTL and testbench

Sequences the LED display phase of the game. On a start pulse it reads the stored color sequence from the synchronous sequence RAM, entry by entry from address 0 up to a supplied limit. Each color is shown for a programmable on-time, followed by a programmable blank interval. It sits between the game control unit and the datapath, and it replaces per-LED timer handling in the main FSM with a start/done handshake.

---
 rtl/sequenciador_exibicao_pkg.sv | 22 ++
 rtl/sequenciador_exibicao_contador.sv | 41 ++++
 rtl/sequenciador_exibicao.sv | 154 +++++++++++++++
 tb/tb_sequenciador_exibicao.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_exibicao_pkg.sv
// Game-wide constants and state codes for the LED display sequencer.
package sequenciador_exibicao_pkg;

    localparam int unsigned ADDR_W_PADRAO      = 4;
    localparam int unsigned DATA_W_PADRAO      = 4;
    localparam int unsigned TIMER_W_PADRAO     = 16;
    localparam int unsigned T_ACESO_PADRAO     = 1000;
    localparam int unsigned T_APAGADO_PADRAO   = 500;
    localparam int unsigned T_ACESO_R_PADRAO   = 500;
    localparam int unsigned T_APAGADO_R_PADRAO = 250;

    typedef enum logic [2:0] {
        OCIOSO   = 3'b000,
        ENDERECA = 3'b001,
        CARREGA  = 3'b010,
        ACESO    = 3'b011,
        APAGADO  = 3'b100,
        PROXIMO  = 3'b101,
        FIM      = 3'b110
    } estado_t;

endpackage

// File: rtl/sequenciador_exibicao_contador.sv
// Interval down-counter: load has priority over decrement, registered zero flag.
module contador_intervalo
    import sequenciador_exibicao_pkg::*;
#(
    parameter int unsigned TIMER_W = TIMER_W_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega_i,
    input  logic [TIMER_W-1:0] valor_i,
    input  logic               decrementa_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] conta_q;
    logic [TIMER_W-1:0] conta_d;
    logic               zero_q;

    always_comb begin
        conta_d = conta_q;
        if (carrega_i) begin
            conta_d = valor_i;
        end else if (decrementa_i && (conta_q != '0)) begin
            conta_d = conta_q - TIMER_W'(1);
        end
    end

    // Zero flag tracks the value being written so it is valid the cycle the count lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conta_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            conta_q <= conta_d;
            zero_q  <= (conta_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/sequenciador_exibicao.sv
// LED display sequencer: walks the color RAM from 0 to limite, showing each color then blanking.
module sequenciador_exibicao
    import sequenciador_exibicao_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_PADRAO,
    parameter int unsigned DATA_W      = DATA_W_PADRAO,
    parameter int unsigned TIMER_W     = TIMER_W_PADRAO,
    parameter int unsigned T_ACESO     = T_ACESO_PADRAO,
    parameter int unsigned T_APAGADO   = T_APAGADO_PADRAO,
    parameter int unsigned T_ACESO_R   = T_ACESO_R_PADRAO,
    parameter int unsigned T_APAGADO_R = T_APAGADO_R_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
    input  logic              modo_rapido,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    localparam logic [TIMER_W-1:0] CARGA_ACESO     = TIMER_W'(T_ACESO - 1);
    localparam logic [TIMER_W-1:0] CARGA_APAGADO   = TIMER_W'(T_APAGADO - 1);
    localparam logic [TIMER_W-1:0] CARGA_ACESO_R   = TIMER_W'(T_ACESO_R - 1);
    localparam logic [TIMER_W-1:0] CARGA_APAGADO_R = TIMER_W'(T_APAGADO_R - 1);

    estado_t             estado_q, estado_d;
    logic [ADDR_W-1:0]   endereco_q, endereco_d;
    logic [ADDR_W-1:0]   limite_q, limite_d;
    logic                modo_q, modo_d;
    logic [DATA_W-1:0]   cor_q, cor_d;
    logic [DATA_W-1:0]   leds_q, leds_d;
    logic                ocupado_q, ocupado_d;
    logic                pronto_q, pronto_d;
    logic                carrega;
    logic                decrementa;
    logic [TIMER_W-1:0]  valor;
    logic                zero;

    contador_intervalo #(
        .TIMER_W (TIMER_W)
    ) u_contador (
        .clock        (clock),
        .reset        (reset),
        .carrega_i    (carrega),
        .valor_i      (valor),
        .decrementa_i (decrementa),
        .zero_o       (zero)
    );

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        modo_d     = modo_q;
        cor_d      = cor_q;
        carrega    = 1'b0;
        decrementa = 1'b0;
        valor      = modo_q ? CARGA_ACESO_R : CARGA_ACESO;

        case (estado_q)
            OCIOSO: begin
                endereco_d = '0;
                if (iniciar) begin
                    limite_d = limite;
                    modo_d   = modo_rapido;
                    estado_d = ENDERECA;
                end
            end
            ENDERECA: estado_d = CARREGA;
            CARREGA: begin
                cor_d    = dado_mem;
                carrega  = 1'b1;
                estado_d = ACESO;
            end
            ACESO: begin
                if (zero) begin
                    carrega  = 1'b1;
                    valor    = modo_q ? CARGA_APAGADO_R : CARGA_APAGADO;
                    estado_d = APAGADO;
                end else begin
                    decrementa = 1'b1;
                end
            end
            APAGADO: begin
                if (zero) begin
                    estado_d = (endereco_q == limite_q) ? FIM : PROXIMO;
                end else begin
                    decrementa = 1'b1;
                end
            end
            PROXIMO: begin
                endereco_d = endereco_q + ADDR_W'(1);
                estado_d   = ENDERECA;
            end
            FIM: begin
                endereco_d = '0;
                estado_d   = OCIOSO;
            end
            default: begin
                endereco_d = '0;
                estado_d   = OCIOSO;
            end
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (abortar) begin
            estado_d   = OCIOSO;
            endereco_d = '0;
            limite_d   = limite_q;
            modo_d     = modo_q;
            carrega    = 1'b0;
            decrementa = 1'b0;
        end
    end

    assign leds_d    = (estado_d == ACESO) ? cor_d : '0;
    assign ocupado_d = (estado_d != OCIOSO);
    assign pronto_d  = (estado_d == FIM);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            limite_q   <= '0;
            modo_q     <= 1'b0;
            cor_q      <= '0;
            leds_q     <= '0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            modo_q     <= modo_d;
            cor_q      <= cor_d;
            leds_q     <= leds_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign endereco  = endereco_q;
    assign leds      = leds_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Directed self-checking bench for sequenciador_exibicao with short intervals.
module tb_sequenciador_exibicao;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic       modo_rapido;
    logic [3:0] limite;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    logic [3:0]  ram [16];
    logic [12:0] obs_tr [64];
    int checks = 0;
    int errors = 0;

    sequenciador_exibicao #(
        .T_ACESO     (4),
        .T_APAGADO   (2),
        .T_ACESO_R   (2),
        .T_APAGADO_R (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .abortar     (abortar),
        .modo_rapido (modo_rapido),
        .limite      (limite),
        .dado_mem    (dado_mem),
        .endereco    (endereco),
        .leds        (leds),
        .ocupado     (ocupado),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: data appears one cycle after the address.
    always @(posedge clock) dado_mem <= ram[endereco];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Expected {state, leds, endereco, ocupado, pronto} at cycle i after the start-sampling edge.
    function automatic logic [12:0] exp_cycle(input int i, input int lim, input int ton, input int toff);
        int l;
        int fim;
        int k;
        int o;
        logic [2:0] s;
        logic [3:0] ld;
        l   = 2 + ton + toff;
        fim = (lim + 1) * l + lim;
        if (i > fim) return 13'd0;
        if (i == fim) return {3'd6, 4'd0, 4'(lim), 1'b1, 1'b1};
        k  = i / (l + 1);
        o  = i % (l + 1);
        ld = 4'd0;
        if (o == 0)             s = 3'd1;
        else if (o == 1)        s = 3'd2;
        else if (o < 2 + ton) begin s = 3'd3; ld = ram[k]; end
        else if (o < l)         s = 3'd4;
        else                    s = 3'd5;
        return {s, ld, 4'(k), 1'b1, 1'b0};
    endfunction

    // Pulses iniciar, then records n cycles; at poke_at the given inputs are applied for one cycle.
    task automatic capture(input int n, input int poke_at, input logic poke_ini,
                           input logic [3:0] poke_lim, input logic poke_modo);
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        for (int i = 0; i < n; i++) begin
            obs_tr[i] = {db_estado, leds, endereco, ocupado, pronto};
            if (i == poke_at) begin
                iniciar     = poke_ini;
                limite      = poke_lim;
                modo_rapido = poke_modo;
            end else begin
                iniciar = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({db_estado, leds, endereco, ocupado, pronto} !== 13'd0) begin
            errors++;
            $display("FAIL reset_values: got %h want 0000", {db_estado, leds, endereco, ocupado, pronto});
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (db_estado !== 3'd0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got state %0d ocupado %b want 0 0", db_estado, ocupado);
        end
    endtask

    task automatic test_normal();
        int nerr = 0;
        int first = -1;
        int pidx = -1;
        limite = 4'd2; modo_rapido = 1'b0;
        capture(29, -1, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 29; i++) begin
            if (obs_tr[i] !== exp_cycle(i, 2, 4, 2)) begin
                nerr++;
                if (first < 0) first = i;
            end
            if (obs_tr[i][0] === 1'b1 && pidx < 0) pidx = i;
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL normal_trace: %0d bad cycles, first %0d got %h want %h",
                     nerr, first, obs_tr[first], exp_cycle(first, 2, 4, 2));
        end
        checks++;
        if (pidx != 26) begin
            errors++;
            $display("FAIL normal_pronto_time: got cycle %0d want 26 after sampling edge", pidx);
        end
        checks++;
        if (ocupado !== 1'b0 || endereco !== 4'd0 || pronto !== 1'b0) begin
            errors++;
            $display("FAIL normal_end: got ocupado %b endereco %0d pronto %b want 0 0 0", ocupado, endereco, pronto);
        end
    endtask

    task automatic test_limite_zero();
        int nerr = 0;
        int first = -1;
        int bad_addr = 0;
        ram[0] = 4'b1000;
        limite = 4'd0; modo_rapido = 1'b0;
        capture(11, -1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (obs_tr[i] !== exp_cycle(i, 0, 4, 2)) begin
                nerr++;
                if (first < 0) first = i;
            end
            if (obs_tr[i][5:2] !== 4'd0 || obs_tr[i][12:10] === 3'd5) bad_addr++;
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL limite0_trace: %0d bad cycles, first %0d got %h want %h",
                     nerr, first, obs_tr[first], exp_cycle(first, 0, 4, 2));
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL limite0_addr: got %0d cycles with endereco!=0 or PROXIMO want 0", bad_addr);
        end
        ram[0] = 4'b0001;
    endtask

    task automatic test_fast();
        int nerr = 0;
        int first = -1;
        limite = 4'd1; modo_rapido = 1'b1;
        capture(14, 3, 1'b0, 4'd1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            if (obs_tr[i] !== exp_cycle(i, 1, 2, 1)) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL fast_trace: %0d bad cycles, first %0d got %h want %h",
                     nerr, first, obs_tr[first], exp_cycle(first, 1, 2, 1));
        end
        checks++;
        if (obs_tr[11][0] !== 1'b1 || obs_tr[10][0] !== 1'b0) begin
            errors++;
            $display("FAIL fast_pronto_time: got pronto[10]=%b pronto[11]=%b want 0 1", obs_tr[10][0], obs_tr[11][0]);
        end
    endtask

    task automatic test_abort();
        int nerr = 0;
        int first = -1;
        int spurious = 0;
        limite = 4'd2; modo_rapido = 1'b0;
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        repeat (12) @(negedge clock);
        checks++;
        if (db_estado !== 3'd3 || endereco !== 4'd1 || leds !== 4'b0010) begin
            errors++;
            $display("FAIL abort_precond: got state %0d endereco %0d leds %b want 3 1 0010", db_estado, endereco, leds);
        end
        abortar = 1'b1;
        @(negedge clock); abortar = 1'b0;
        checks++;
        if ({db_estado, leds, endereco, ocupado, pronto} !== 13'd0) begin
            errors++;
            $display("FAIL abort_next: got %h want 0000", {db_estado, leds, endereco, ocupado, pronto});
        end
        for (int i = 0; i < 30; i++) begin
            if (pronto !== 1'b0 || db_estado !== 3'd0) spurious++;
            @(negedge clock);
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", spurious);
        end
        iniciar = 1'b1; abortar = 1'b1;
        @(negedge clock); iniciar = 1'b0; abortar = 1'b0;
        checks++;
        if (db_estado !== 3'd0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_start: got state %0d ocupado %b want 0 0", db_estado, ocupado);
        end
        capture(29, -1, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 29; i++) begin
            if (obs_tr[i] !== exp_cycle(i, 2, 4, 2)) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL abort_restart_trace: %0d bad cycles, first %0d got %h want %h",
                     nerr, first, obs_tr[first], exp_cycle(first, 2, 4, 2));
        end
    endtask

    task automatic test_ignore_inputs();
        int nerr = 0;
        int first = -1;
        limite = 4'd2; modo_rapido = 1'b0;
        capture(29, 6, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 29; i++) begin
            if (obs_tr[i] !== exp_cycle(i, 2, 4, 2)) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (nerr != 0) begin
            errors++;
            $display("FAIL ignore_trace: %0d bad cycles, first %0d got %h want %h",
                     nerr, first, obs_tr[first], exp_cycle(first, 2, 4, 2));
        end
        limite = 4'd2; modo_rapido = 1'b0;
    endtask

    task automatic test_async_reset();
        int budget = 0;
        limite = 4'd1; modo_rapido = 1'b0;
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        while (db_estado !== 3'd3 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        checks++;
        if (db_estado !== 3'd3) begin
            errors++;
            $display("FAIL areset_reach_aceso: got state %0d want 3 within 20 cycles", db_estado);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({db_estado, leds, endereco, ocupado, pronto} !== 13'd0) begin
            errors++;
            $display("FAIL areset_immediate: got %h want 0000", {db_estado, leds, endereco, ocupado, pronto});
        end
        @(negedge clock); reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (db_estado !== 3'd0 || ocupado !== 1'b0 || leds !== 4'd0) begin
            errors++;
            $display("FAIL areset_after: got state %0d ocupado %b leds %b want 0 0 0000", db_estado, ocupado, leds);
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; modo_rapido = 1'b0; limite = 4'd0;
        for (int i = 0; i < 16; i++) ram[i] = 4'd0;
        ram[0] = 4'b0001; ram[1] = 4'b0010; ram[2] = 4'b0100;
        test_reset();
        test_normal();
        test_limite_zero();
        test_fast();
        test_abort();
        test_ignore_inputs();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
